idex_stage: RTL

ID/EX pipeline stage of the five-stage MIPS core: registers decoded instruction fields, register-file read data and control bits from decode, and presents them to execute and to the forwarding unit (`idex_rs`, `idex_rt`). It owns load-use hazard detection and bubble insertion. It also applies branch/jump flushes and holds the pipeline on a halt. It sits between the decode logic and `forward_unit`/EX.

---
 rtl/cpu_types_pkg.sv | 50 +++++
 rtl/idex_stage_if.sv | 35 +++
 rtl/load_use_detect.sv | 27 ++
 rtl/idex_stage.sv | 117 +++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// cpu_types_pkg: shared word/field types and the ID/EX latch layout.
// Revision: 1.0

package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [5:0]        opcode_t;
    typedef logic [5:0]        funct_t;
    typedef logic [4:0]        regbits_t;
    typedef logic [3:0]        aluop_t;

    typedef struct packed {
        logic   regW;
        logic   memR;
        logic   memW;
        logic   alusrc;
        aluop_t aluop;
        logic   halt;
        logic   uses_rt;
    } idex_ctrl_t;

    typedef struct packed {
        logic        valid;
        opcode_t     op;
        funct_t      funct;
        regbits_t    rs;
        regbits_t    rt;
        regbits_t    rd;
        logic [15:0] imm;
        logic [4:0]  shamt;
        word_t       rdat1;
        word_t       rdat2;
        word_t       npc;
        idex_ctrl_t  ctrl;
    } idex_t;

    // All-zero latch decodes as an SLL nop with no side effects.
    localparam idex_t IDEX_BUBBLE = '0;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } idex_state_t;

endpackage

`default_nettype wire

// File: rtl/idex_stage_if.sv
`default_nettype none
// idex_stage_if: bundle of the ID/EX stage signals, stage-side view in modport idex.
// Revision: 1.0

interface idex_stage_if;
    import cpu_types_pkg::*;

    logic        ihit, mem_stall, flush, id_valid;
    opcode_t     id_op;
    funct_t      id_funct;
    regbits_t    id_rs, id_rt, id_rd;
    logic [15:0] id_imm;
    logic [4:0]  id_shamt;
    word_t       id_rdat1, id_rdat2, id_npc;
    idex_ctrl_t  id_ctrl;

    logic        idex_valid;
    opcode_t     idex_op;
    funct_t      idex_funct;
    regbits_t    idex_rs, idex_rt, idex_rd;
    logic [15:0] idex_imm;
    logic [4:0]  idex_shamt;
    word_t       idex_rdat1, idex_rdat2, idex_npc;
    idex_ctrl_t  idex_ctrl;
    logic        lu_stall, halted;

    modport idex (
        input  ihit, mem_stall, flush, id_valid, id_op, id_funct, id_rs, id_rt, id_rd,
               id_imm, id_shamt, id_rdat1, id_rdat2, id_npc, id_ctrl,
        output idex_valid, idex_op, idex_funct, idex_rs, idex_rt, idex_rd, idex_imm,
               idex_shamt, idex_rdat1, idex_rdat2, idex_npc, idex_ctrl, lu_stall, halted
    );
endinterface

`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// load_use_detect: flags a decode instruction that reads the register a load in EX is writing.
// Revision: 1.0

module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_valid_i,
    input  logic     ex_memR_i,
    input  logic     ex_regW_i,
    input  regbits_t ex_rt_i,
    input  logic     id_valid_i,
    input  regbits_t id_rs_i,
    input  regbits_t id_rt_i,
    input  logic     id_uses_rt_i,
    output logic     hazard_o
);
    logic w_ex_load;
    logic w_dep;

    // $0 is hardwired, so a load targeting it never produces a value to wait for.
    assign w_ex_load = ex_valid_i & ex_memR_i & ex_regW_i & (ex_rt_i != '0);
    assign w_dep     = (id_rs_i == ex_rt_i) | (id_uses_rt_i & (id_rt_i == ex_rt_i));
    assign hazard_o  = w_ex_load & id_valid_i & w_dep;
endmodule

`default_nettype wire

// File: rtl/idex_stage.sv
`default_nettype none
// idex_stage: ID/EX pipeline latch with load-use bubble insertion, flush and halt freeze.
// Revision: 1.0

module idex_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        mem_stall,
    input  logic        flush,
    input  logic        id_valid,
    input  opcode_t     id_op,
    input  funct_t      id_funct,
    input  regbits_t    id_rs,
    input  regbits_t    id_rt,
    input  regbits_t    id_rd,
    input  logic [15:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  word_t       id_rdat1,
    input  word_t       id_rdat2,
    input  word_t       id_npc,
    input  idex_ctrl_t  id_ctrl,
    output logic        idex_valid,
    output opcode_t     idex_op,
    output funct_t      idex_funct,
    output regbits_t    idex_rs,
    output regbits_t    idex_rt,
    output regbits_t    idex_rd,
    output logic [15:0] idex_imm,
    output logic [4:0]  idex_shamt,
    output word_t       idex_rdat1,
    output word_t       idex_rdat2,
    output word_t       idex_npc,
    output idex_ctrl_t  idex_ctrl,
    output logic        lu_stall,
    output logic        halted
);
    idex_t       latch_q, latch_d;
    idex_state_t state_q, state_d;
    logic        advance;
    logic        lu_hit;

    load_use_detect u_load_use (
        .ex_valid_i   (latch_q.valid),
        .ex_memR_i    (latch_q.ctrl.memR),
        .ex_regW_i    (latch_q.ctrl.regW),
        .ex_rt_i      (latch_q.rt),
        .id_valid_i   (id_valid),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_uses_rt_i (id_ctrl.uses_rt),
        .hazard_o     (lu_hit)
    );

    assign advance  = ihit & ~mem_stall;
    assign lu_stall = lu_hit & ~flush & (state_q == RUN);

    always_comb begin
        latch_d = latch_q;
        state_d = state_q;
        if (mem_stall) begin
            latch_d = latch_q;
        end else if (flush) begin
            // The branch is older than any halt behind it, so a flush also releases HALTED.
            latch_d = IDEX_BUBBLE;
            state_d = RUN;
        end else if (state_q == HALTED) begin
            latch_d = latch_q;
        end else if (advance && lu_stall) begin
            latch_d = IDEX_BUBBLE;
        end else if (advance) begin
            latch_d.valid = id_valid;
            latch_d.op    = id_op;
            latch_d.funct = id_funct;
            latch_d.rs    = id_rs;
            latch_d.rt    = id_rt;
            latch_d.rd    = id_rd;
            latch_d.imm   = id_imm;
            latch_d.shamt = id_shamt;
            latch_d.rdat1 = id_rdat1;
            latch_d.rdat2 = id_rdat2;
            latch_d.npc   = id_npc;
            latch_d.ctrl  = id_ctrl;
            if (id_valid && id_ctrl.halt) begin
                state_d = HALTED;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            latch_q <= IDEX_BUBBLE;
            state_q <= RUN;
        end else begin
            latch_q <= latch_d;
            state_q <= state_d;
        end
    end

    assign idex_valid = latch_q.valid;
    assign idex_op    = latch_q.op;
    assign idex_funct = latch_q.funct;
    assign idex_rs    = latch_q.rs;
    assign idex_rt    = latch_q.rt;
    assign idex_rd    = latch_q.rd;
    assign idex_imm   = latch_q.imm;
    assign idex_shamt = latch_q.shamt;
    assign idex_rdat1 = latch_q.rdat1;
    assign idex_rdat2 = latch_q.rdat2;
    assign idex_npc   = latch_q.npc;
    assign idex_ctrl  = latch_q.ctrl;
    assign halted     = (state_q == HALTED);
endmodule

`default_nettype wire
